dmem_arbiter: RTL

Shares the byte-wide, synchronous-read data memory between two word-access requesters: the CPU load/store path (port 0) and a host/loader port (port 1) used to preload and read back matrix and vector operands. Each granted request is serialised into four byte cycles, big-endian: the byte at the base address holds bits 31:24. The block sits between the multicycle core's MEM stage and the data-memory array, and replaces the core's direct array indexing.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-requester data-memory arbiter: both requester ports,
// the byte-wide memory side and a debug view of the arbiter FSM.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8
);
    // Requester handshake: hold req (with stable fields) until gnt pulses; the
    // fields are latched on gnt and may change afterwards. done pulses once when
    // the access completes, and rdata carries the load word from that cycle on.
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wdata;
    logic              p0_gnt;
    logic              p0_done;
    logic [31:0]       p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wdata;
    logic              p1_gnt;
    logic              p1_done;
    logic [31:0]       p1_rdata;

    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [1:0]        dbg_state;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_done, p0_rdata,
        output p1_gnt, p1_done, p1_rdata,
        output busy, mem_addr, mem_we, mem_wdata, dbg_state
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_done, p0_rdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  busy, mem_addr, mem_we, mem_wdata, dbg_state
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises 32-bit word accesses from two requesters
// into four big-endian byte cycles on a synchronous-read byte memory.
module dmem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [23:0]       r_acc;
    logic              r_p0_gnt;
    logic              r_p1_gnt;
    logic              r_p0_done;
    logic              r_p1_done;
    logic [31:0]       r_p0_rdata;
    logic [31:0]       r_p1_rdata;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;

    logic              w_any;
    logic              w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [1:0]        w_next_cnt;
    logic [ADDR_W-1:0] w_next_addr;
    logic [7:0]        w_next_byte;

    // On a tie the port that was not granted last wins; r_last resets to port 1.
    assign w_any       = bus.p0_req | bus.p1_req;
    assign w_sel       = ~(bus.p0_req & (~bus.p1_req | r_last));
    assign w_sel_we    = w_sel ? bus.p1_we    : bus.p0_we;
    assign w_sel_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;
    assign w_next_cnt  = r_cnt + 2'd1;
    assign w_next_addr = r_base + ADDR_W'(w_next_cnt);

    always_comb begin
        w_next_byte = r_wdata[31:24];
        case (w_next_cnt)
            2'd1:    w_next_byte = r_wdata[23:16];
            2'd2:    w_next_byte = r_wdata[15:8];
            2'd3:    w_next_byte = r_wdata[7:0];
            default: w_next_byte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_we        <= 1'b0;
            r_base      <= '0;
            r_wdata     <= 32'h0;
            r_acc       <= 24'h0;
            r_p0_gnt    <= 1'b0;
            r_p1_gnt    <= 1'b0;
            r_p0_done   <= 1'b0;
            r_p1_done   <= 1'b0;
            r_p0_rdata  <= 32'h0;
            r_p1_rdata  <= 32'h0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h0;
        end else begin
            r_p0_gnt  <= 1'b0;
            r_p1_gnt  <= 1'b0;
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_sel;
                        r_last      <= w_sel;
                        r_we        <= w_sel_we;
                        r_base      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_cnt       <= 2'd0;
                        r_busy      <= 1'b1;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_we    <= w_sel_we;
                        r_mem_wdata <= w_sel_wdata[31:24];
                        r_p0_gnt    <= ~w_sel;
                        r_p1_gnt    <= w_sel;
                        r_state     <= XFER;
                    end
                end
                XFER: begin
                    // Read data lags the address by one cycle, so cnt=k sees byte k-1.
                    if (!r_we) begin
                        case (r_cnt)
                            2'd1:    r_acc[23:16] <= bus.mem_rdata;
                            2'd2:    r_acc[15:8]  <= bus.mem_rdata;
                            2'd3:    r_acc[7:0]   <= bus.mem_rdata;
                            default: ;
                        endcase
                    end
                    if (r_cnt == 2'd3) begin
                        r_mem_we <= 1'b0;
                        if (r_we) begin
                            r_p0_done <= ~r_owner;
                            r_p1_done <= r_owner;
                            r_state   <= DONE;
                        end else begin
                            r_state   <= TAIL;
                        end
                    end else begin
                        r_cnt       <= w_next_cnt;
                        r_mem_addr  <= w_next_addr;
                        r_mem_wdata <= w_next_byte;
                    end
                end
                TAIL: begin
                    if (r_owner) r_p1_rdata <= {r_acc, bus.mem_rdata};
                    else         r_p0_rdata <= {r_acc, bus.mem_rdata};
                    r_p0_done <= ~r_owner;
                    r_p1_done <= r_owner;
                    r_state   <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.p0_gnt    = r_p0_gnt;
    assign bus.p1_gnt    = r_p1_gnt;
    assign bus.p0_done   = r_p0_done;
    assign bus.p1_done   = r_p1_done;
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;
    assign bus.busy      = r_busy;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.dbg_state = r_state;
endmodule
